// File: rtl/pwm_arbiter_if.sv
// Bus between the PWM arbiter and its requesters / shared pwm generator.
// The slave side is the arbiter; the master side drives requests and pwm_in.
interface pwm_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_duty;
  logic [4*NREQ-1:0] req_freq;
  logic              pwm_in;
  logic              pen;
  logic [3:0]        duty;
  logic [3:0]        freq;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic              err;

  modport master (
    output req, req_duty, req_freq, pwm_in,
    input  pen, duty, freq, grant, done, err
  );

  modport slave (
    input  req, req_duty, req_freq, pwm_in,
    output pen, duty, freq, grant, done, err
  );
endinterface

// File: rtl/pwm_arbiter.sv
// Round-robin owner of one shared pwm generator: grants a requester for up to
// BURST periods, then holds pen low for a GAP drain so settings never change mid-period.
module pwm_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST   = 8,
  parameter int GAP     = 20,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetb,
  pwm_arbiter_if.slave  bus
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int GW   = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t            r_state, w_state;
  logic [PW-1:0]     r_sel, w_sel;
  logic [PW-1:0]     r_ptr, w_ptr;
  logic [7:0]        r_pcnt, w_pcnt;
  logic [WD_W-1:0]   r_wd, w_wd;
  logic [GW-1:0]     r_gcnt, w_gcnt;
  logic              r_pwm_q;
  logic              r_pen, w_pen;
  logic [3:0]        r_duty, w_duty;
  logic [3:0]        r_freq, w_freq;
  logic [NREQ-1:0]   r_grant, w_grant;
  logic              r_done, w_done;
  logic              r_err, w_err;

  logic              w_rise;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic              w_rel;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign w_rise = bus.pwm_in & ~r_pwm_q;

  // First requesting index at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_ptr   = r_ptr;
    w_pcnt  = r_pcnt;
    w_wd    = r_wd;
    w_gcnt  = r_gcnt;
    w_pen   = r_pen;
    w_duty  = r_duty;
    w_freq  = r_freq;
    w_grant = r_grant;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_rel   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pen   = 1'b0;
        w_grant = '0;
        if (w_found) begin
          w_sel   = w_win;
          w_grant = NREQ'(1) << w_win;
          w_duty  = bus.req_duty[int'(w_win)*4 +: 4];
          w_freq  = bus.req_freq[int'(w_win)*4 +: 4];
          w_pen   = 1'b1;
          w_pcnt  = '0;
          w_wd    = '0;
          w_state = ACTIVE;
        end
      end
      ACTIVE: begin
        // A period start wins over a watchdog expiry landing on the same cycle.
        if (w_rise) begin
          w_pcnt = r_pcnt + 8'd1;
          w_wd   = '0;
          if (w_pcnt == 8'(BURST) || !bus.req[r_sel]) begin
            w_done = 1'b1;
            w_rel  = 1'b1;
          end
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_err = 1'b1;
          w_rel = 1'b1;
        end else begin
          w_wd = r_wd + 1'b1;
        end
        if (w_rel) begin
          w_pen   = 1'b0;
          w_grant = '0;
          w_ptr   = inc_mod(r_sel);
          w_gcnt  = '0;
          w_state = DRAIN;
        end
      end
      DRAIN: begin
        w_pen   = 1'b0;
        w_grant = '0;
        if (r_gcnt == GW'(GAP - 1)) begin
          w_state = IDLE;
        end else begin
          w_gcnt = r_gcnt + 1'b1;
        end
      end
      default: begin
        w_pen   = 1'b0;
        w_grant = '0;
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_pcnt  <= '0;
      r_wd    <= '0;
      r_gcnt  <= '0;
      r_pwm_q <= 1'b0;
      r_pen   <= 1'b0;
      r_duty  <= '0;
      r_freq  <= '0;
      r_grant <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_ptr   <= w_ptr;
      r_pcnt  <= w_pcnt;
      r_wd    <= w_wd;
      r_gcnt  <= w_gcnt;
      r_pwm_q <= bus.pwm_in;
      r_pen   <= w_pen;
      r_duty  <= w_duty;
      r_freq  <= w_freq;
      r_grant <= w_grant;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign bus.pen   = r_pen;
  assign bus.duty  = r_duty;
  assign bus.freq  = r_freq;
  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
endmodule
